// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low key matrix front end for the calculator
// controller. Scans rows one-cold, synchronises and debounces the column
// lines, and turns each accepted press into exactly one controller event:
// a digit with a read strobe, a held one-hot operator, an equal strobe or a
// clear strobe. There is no auto-repeat and no rollover (first key wins).
//
// Handshake: the outputs carry no ready/acknowledge. read_input,
// equal_input and clear are single-cycle valid pulses that the controller
// must sample in the cycle they are high. keypad_input and operator_input
// are level outputs that hold until the next event changes them.
module keypad_scanner #(
    parameter int SCAN_CYCLES  = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear,
    output logic       busy
);

    localparam int SLOT_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b100;

    // Scanner states; kept as a named signal so checkers can bind to it.
    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    // Meaning of the key at the latched (row, column) position.
    typedef enum logic [2:0] {
        K_DIGIT = 3'd0,
        K_ADD   = 3'd1,
        K_SUB   = 3'd2,
        K_MUL   = 3'd3,
        K_EQ    = 3'd4,
        K_CLR   = 3'd5,
        K_NOP   = 3'd6
    } key_kind_t;

    state_t            state;
    logic [1:0]        row_idx;
    logic [1:0]        next_row;
    logic [1:0]        key_col;
    logic [SLOT_W-1:0] slot_cnt;
    logic [DEB_W-1:0]  deb_cnt;
    logic              eq_flag;

    logic [3:0]        col_meta;
    logic [3:0]        col_s;

    logic              col_hit;
    logic [1:0]        hit_col;
    logic              key_low;

    key_kind_t         key_kind;
    logic [3:0]        key_digit;

    // Row drive pattern: only the indexed row is pulled low.
    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        one_cold = ~(4'b0001 << idx);
    endfunction

    // Two-flop synchroniser for the asynchronous column inputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    // Lowest-index low column of the synchronised value.
    always_comb begin
        col_hit = 1'b1;
        hit_col = 2'd0;
        if (!col_s[0]) begin
            hit_col = 2'd0;
        end else if (!col_s[1]) begin
            hit_col = 2'd1;
        end else if (!col_s[2]) begin
            hit_col = 2'd2;
        end else if (!col_s[3]) begin
            hit_col = 2'd3;
        end else begin
            col_hit = 1'b0;
        end
    end

    assign key_low  = ~col_s[key_col];
    assign next_row = row_idx + 2'd1;

    // Key map decode for the latched row and column.
    always_comb begin
        key_kind  = K_NOP;
        key_digit = 4'd0;
        case (row_idx)
            2'd0: begin
                case (key_col)
                    2'd0:    begin key_kind = K_DIGIT; key_digit = 4'd1; end
                    2'd1:    begin key_kind = K_DIGIT; key_digit = 4'd2; end
                    2'd2:    begin key_kind = K_DIGIT; key_digit = 4'd3; end
                    default: key_kind = K_ADD;
                endcase
            end
            2'd1: begin
                case (key_col)
                    2'd0:    begin key_kind = K_DIGIT; key_digit = 4'd4; end
                    2'd1:    begin key_kind = K_DIGIT; key_digit = 4'd5; end
                    2'd2:    begin key_kind = K_DIGIT; key_digit = 4'd6; end
                    default: key_kind = K_SUB;
                endcase
            end
            2'd2: begin
                case (key_col)
                    2'd0:    begin key_kind = K_DIGIT; key_digit = 4'd7; end
                    2'd1:    begin key_kind = K_DIGIT; key_digit = 4'd8; end
                    2'd2:    begin key_kind = K_DIGIT; key_digit = 4'd9; end
                    default: key_kind = K_MUL;
                endcase
            end
            default: begin
                case (key_col)
                    2'd0:    key_kind = K_CLR;
                    2'd1:    begin key_kind = K_DIGIT; key_digit = 4'd0; end
                    2'd2:    key_kind = K_EQ;
                    default: key_kind = K_NOP;
                endcase
            end
        endcase
    end

    // Scan / debounce state machine with registered event outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state          <= SCAN;
            row_idx        <= 2'd0;
            row_n          <= 4'b1110;
            key_col        <= 2'd0;
            slot_cnt       <= '0;
            deb_cnt        <= '0;
            eq_flag        <= 1'b0;
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= OP_NONE;
            equal_input    <= 1'b0;
            clear          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless an event sets them.
            read_input  <= 1'b0;
            equal_input <= 1'b0;
            clear       <= 1'b0;

            case (state)
                SCAN: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (col_hit) begin
                            key_col <= hit_col;
                            deb_cnt <= '0;
                            state   <= DEB_PRESS;
                            busy    <= 1'b1;
                        end else begin
                            row_idx <= next_row;
                            row_n   <= one_cold(next_row);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + SLOT_ONE;
                    end
                end

                DEB_PRESS: begin
                    if (key_low) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt <= '0;
                            state   <= HELD;
                            // Emit the event for the accepted key.
                            case (key_kind)
                                K_DIGIT: begin
                                    keypad_input <= key_digit;
                                    read_input   <= 1'b1;
                                    if (eq_flag) begin
                                        operator_input <= OP_NONE;
                                        eq_flag        <= 1'b0;
                                    end
                                end
                                K_ADD: operator_input <= OP_ADD;
                                K_SUB: operator_input <= OP_SUB;
                                K_MUL: operator_input <= OP_MUL;
                                K_EQ: begin
                                    // Operator is kept so the controller can use it after equal.
                                    equal_input <= 1'b1;
                                    eq_flag     <= 1'b1;
                                end
                                K_CLR: begin
                                    clear          <= 1'b1;
                                    operator_input <= OP_NONE;
                                    eq_flag        <= 1'b0;
                                end
                                default: ;
                            endcase
                        end else begin
                            deb_cnt <= deb_cnt + DEB_ONE;
                        end
                    end else begin
                        // Glitch: resume scanning on the following row.
                        deb_cnt  <= '0;
                        slot_cnt <= '0;
                        row_idx  <= next_row;
                        row_n    <= one_cold(next_row);
                        state    <= SCAN;
                        busy     <= 1'b0;
                    end
                end

                HELD: begin
                    if (!key_low) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
                end

                DEB_REL: begin
                    if (!key_low) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt  <= '0;
                            slot_cnt <= '0;
                            row_idx  <= next_row;
                            row_n    <= one_cold(next_row);
                            state    <= SCAN;
                            busy     <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_ONE;
                        end
                    end else begin
                        // Release bounced; the key is still considered held.
                        deb_cnt <= '0;
                        state   <= HELD;
                    end
                end

                default: begin
                    state <= SCAN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
